// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with an internal tick prescaler and sample-rate scaling.
// Define ADSR_VEL_EN to derive the peak level from note velocity; otherwise the peak is fixed at 255.
module adsr_envelope #(
    parameter int PRESCALER_MODULO   = 500,
    parameter int PRESCALER_MODULO_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_on,
    input  logic       note_off,
    input  logic [6:0] note_vel,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] release_rate,
    input  logic [3:0] sustain,
    input  logic       sample_ce,
    input  logic [7:0] sample_in,
    output logic [7:0] sample_out,
    output logic [7:0] env_out,
    output logic [2:0] state_out,
    output logic       active
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                        state;
    state_t                        state_next;
    logic [7:0]                    env;
    logic [7:0]                    env_next;
    logic [7:0]                    peak;
    logic [7:0]                    sus;
    logic [7:0]                    peak_new;
    logic [7:0]                    sus_new;
    logic [15:0]                   sus_prod;
    logic [PRESCALER_MODULO_W-1:0] prescale;
    logic                          tick;
    logic                          start;
    logic                          stop;
    logic [4:0]                    step_a;
    logic [4:0]                    step_d;
    logic [4:0]                    step_r;
    logic [8:0]                    attack_sum;
    logic [8:0]                    decay_floor;
    logic signed [17:0]            centered;
    logic signed [17:0]            product;
    logic signed [9:0]             scaled;

    assign tick = (prescale == PRESCALER_MODULO_W'(PRESCALER_MODULO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PRESCALER_MODULO_W'(1);
        end
    end

`ifdef ADSR_VEL_EN
    assign peak_new = {note_vel, note_vel[6]};
`else
    assign peak_new = 8'hFF;
`endif

    assign sus_prod = {8'd0, peak_new} * {8'd0, sustain, sustain};
    assign sus_new  = 8'(sus_prod >> 8);

    // A zero-velocity note_on acts as note_off; a real note_on always wins.
    assign start = note_on && (note_vel != 7'd0);
    assign stop  = (note_off || note_on) &&
                   (state == ATTACK || state == DECAY || state == SUSTAIN);

    assign step_a      = 5'd16 - {1'b0, attack};
    assign step_d      = 5'd16 - {1'b0, decay};
    assign step_r      = 5'd16 - {1'b0, release_rate};
    assign attack_sum  = {1'b0, env} + {4'd0, step_a};
    assign decay_floor = {1'b0, sus} + {4'd0, step_d};

    always_comb begin
        state_next = state;
        env_next   = env;
        if (start) begin
            state_next = ATTACK;
        end else if (stop) begin
            state_next = RELEASE;
        end else if (tick) begin
            case (state)
                ATTACK: begin
                    if (attack_sum >= {1'b0, peak}) begin
                        env_next   = peak;
                        state_next = DECAY;
                    end else begin
                        env_next = attack_sum[7:0];
                    end
                end
                DECAY: begin
                    if ({1'b0, env} <= decay_floor) begin
                        env_next   = sus;
                        state_next = SUSTAIN;
                    end else begin
                        env_next = env - {3'd0, step_d};
                    end
                end
                RELEASE: begin
                    if (env <= {3'd0, step_r}) begin
                        env_next   = '0;
                        state_next = IDLE;
                    end else begin
                        env_next = env - {3'd0, step_r};
                    end
                end
                default: begin
                    env_next = env;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            env   <= '0;
            peak  <= '0;
            sus   <= '0;
        end else begin
            state <= state_next;
            env   <= env_next;
            if (start) begin
                peak <= peak_new;
                sus  <= sus_new;
            end
        end
    end

    // Arithmetic shift floors toward minus infinity, so the result spans 0..254 without clamping.
    assign centered = $signed({10'd0, sample_in}) - 18'sd128;
    assign product  = centered * $signed({10'd0, env});
    assign scaled   = 10'(product >>> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out <= 8'd128;
        end else if (sample_ce) begin
            sample_out <= 8'(scaled + 10'sd128);
        end
    end

    assign env_out   = env;
    assign state_out = state;
    assign active    = (state != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboarded bench for adsr_envelope: a per-cycle arithmetic reference model queues
// expected outputs, a negedge monitor pops and compares them, plus directed constant checks.
module tb_adsr_envelope;

    localparam int MOD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       note_on = 1'b0;
    logic       note_off = 1'b0;
    logic [6:0] note_vel = 7'd0;
    logic [3:0] attack = 4'd0;
    logic [3:0] decay = 4'd0;
    logic [3:0] release_rate = 4'd0;
    logic [3:0] sustain = 4'd0;
    logic       sample_ce = 1'b0;
    logic [7:0] sample_in = 8'd128;
    logic [7:0] sample_out;
    logic [7:0] env_out;
    logic [2:0] state_out;
    logic       active;

    typedef struct {
        int env;
        int st;
        int so;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   model_started = 1'b0;

    int m_env = 0;
    int m_st = 0;
    int m_so = 128;
    int m_peak = 0;
    int m_sus = 0;
    int m_pc = 0;
    int m_ticks = 0;

    always #5 clk = ~clk;

    adsr_envelope #(
        .PRESCALER_MODULO  (MOD),
        .PRESCALER_MODULO_W(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .note_on     (note_on),
        .note_off    (note_off),
        .note_vel    (note_vel),
        .attack      (attack),
        .decay       (decay),
        .release_rate(release_rate),
        .sustain     (sustain),
        .sample_ce   (sample_ce),
        .sample_in   (sample_in),
        .sample_out  (sample_out),
        .env_out     (env_out),
        .state_out   (state_out),
        .active      (active)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name, input int missing);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got timeout with %0d still outstanding, expected 0", name, missing);
    endtask

    // Reference model: envelope rules from the datasheet in plain integer arithmetic.
    always @(posedge clk) begin : ref_model
        int   step;
        int   p;
        int   q;
        bit   tick;
        bit   start;
        bit   stop;
        exp_t e;
        if (rst) begin
            m_env  = 0;
            m_st   = 0;
            m_so   = 128;
            m_peak = 0;
            m_sus  = 0;
            m_pc   = 0;
        end else begin
            tick = (m_pc == MOD - 1);
            m_pc = (m_pc + 1) % MOD;
            if (sample_ce) begin
                p = (int'(sample_in) - 128) * m_env;
                q = (p >= 0) ? p / 256 : -((-p + 255) / 256);
                m_so = 128 + q;
            end
            start = note_on && (note_vel != 0);
            stop  = !start && (note_on || note_off) && (m_st >= 1 && m_st <= 3);
            if (start) begin
`ifdef ADSR_VEL_EN
                m_peak = int'(note_vel) * 2 + int'(note_vel) / 64;
`else
                m_peak = 255;
`endif
                m_sus = (m_peak * int'(sustain) * 17) / 256;
                m_st  = 1;
            end else if (stop) begin
                m_st = 4;
            end else if (tick) begin
                m_ticks++;
                if (m_st == 1) begin
                    step = 16 - int'(attack);
                    if (m_env + step >= m_peak) begin
                        m_env = m_peak;
                        m_st  = 2;
                    end else begin
                        m_env = m_env + step;
                    end
                end else if (m_st == 2) begin
                    step = 16 - int'(decay);
                    if (m_env <= m_sus + step) begin
                        m_env = m_sus;
                        m_st  = 3;
                    end else begin
                        m_env = m_env - step;
                    end
                end else if (m_st == 4) begin
                    step = 16 - int'(release_rate);
                    if (m_env <= step) begin
                        m_env = 0;
                        m_st  = 0;
                    end else begin
                        m_env = m_env - step;
                    end
                end
            end
        end
        e.env = m_env;
        e.st  = m_st;
        e.so  = m_so;
        exp_q.push_back(e);
        model_started = 1'b1;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (model_started) begin
            if (exp_q.size() == 0) begin
                report_timeout("scoreboard_empty", 1);
            end else begin
                e = exp_q.pop_front();
                check_output("sb_env_out", env_out, e.env);
                check_output("sb_state_out", state_out, e.st);
                check_output("sb_sample_out", sample_out, e.so);
                check_output("sb_active", active, (e.st != 0) ? 1 : 0);
            end
        end
    end

    task automatic drive(input logic on, input logic off, input logic [6:0] vel,
                         input logic ce, input logic [7:0] smp);
        note_on   = on;
        note_off  = off;
        note_vel  = vel;
        sample_ce = ce;
        sample_in = smp;
    endtask

    task automatic apply_stimulus(input logic on, input logic off, input logic [6:0] vel,
                                  input logic ce, input logic [7:0] smp);
        @(negedge clk);
        drive(on, off, vel, ce, smp);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 1'b0, 7'($urandom_range(0, 127)), ($urandom_range(0, 2) == 0),
                       8'($urandom_range(0, 255)));
    endtask

    task automatic run_ticks(input int n);
        int target;
        int budget;
        target = m_ticks + n;
        budget = n * MOD + 2 * MOD;
        while (m_ticks < target && budget > 0) begin
            idle_cycle();
            budget--;
        end
        if (m_ticks < target) report_timeout("run_ticks", target - m_ticks);
    endtask

    task automatic wait_state(input int st);
        int budget;
        budget = 600;
        while (m_st != st && budget > 0) begin
            idle_cycle();
            budget--;
        end
        if (m_st != st) report_timeout("wait_state", 1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2;
        drive(1'b0, 1'b0, 7'd0, 1'b0, 8'd128);
        rst = 1'b1;
        #1;
        check_output("midnote_reset_env", env_out, 0);
        check_output("midnote_reset_state", state_out, 0);
        check_output("midnote_reset_active", active, 0);
        check_output("midnote_reset_sample", sample_out, 128);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int t0;
        int budget;
        logic on;
        logic off;
        int r;

        attack       = 4'd0;
        decay        = 4'd15;
        release_rate = 4'd0;
        sustain      = 4'd8;
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 7'd0, i[0], 8'd200);
        check_output("reset_sample_out", sample_out, 128);
        check_output("reset_env", env_out, 0);
        check_output("reset_state", state_out, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 7'd0, i[0], 8'd200);
        check_output("idle_sample_out", sample_out, 128);
        check_output("idle_env", env_out, 0);
        check_output("idle_active", active, 0);

        $display("[TB] full attack");
        apply_stimulus(1'b1, 1'b0, 7'd127, 1'b0, 8'd128);
        for (int i = 1; i <= 15; i++) begin
            run_ticks(1);
            check_output($sformatf("attack_tick%0d", i), env_out, 16 * i);
        end
        run_ticks(1);
        check_output("attack_peak_env", env_out, 255);
        check_output("attack_peak_state", state_out, 2);

        t0 = m_ticks;
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 8'd0);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd0);
        check_output("scale_min", sample_out, 0);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 8'd255);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd255);
        check_output("scale_max", sample_out, 254);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd7);
        check_output("scale_hold", sample_out, 254);

        $display("[TB] decay and sustain");
        run_ticks(t0 + 120 - m_ticks);
        check_output("sustain_env", env_out, 135);
        check_output("sustain_state", state_out, 3);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b1, 8'd128);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd128);
        check_output("scale_zero", sample_out, 128);
        run_ticks(50);
        check_output("sustain_hold_env", env_out, 135);
        check_output("sustain_hold_state", state_out, 3);

        $display("[TB] release and retrigger");
        apply_stimulus(1'b0, 1'b1, 7'd0, 1'b0, 8'd128);
        run_ticks(8);
        check_output("release_tick8_env", env_out, 7);
        check_output("release_tick8_state", state_out, 4);
        run_ticks(1);
        check_output("release_done_env", env_out, 0);
        check_output("release_done_state", state_out, 0);
        check_output("release_done_active", active, 0);

        decay = 4'd0;
        apply_stimulus(1'b1, 1'b0, 7'd127, 1'b0, 8'd128);
        run_ticks(16);
        check_output("run2_peak_env", env_out, 255);
        run_ticks(8);
        check_output("run2_sustain_env", env_out, 135);
        check_output("run2_sustain_state", state_out, 3);
        apply_stimulus(1'b0, 1'b1, 7'd0, 1'b0, 8'd128);
        run_ticks(4);
        check_output("run2_release_env", env_out, 71);
        apply_stimulus(1'b1, 1'b0, 7'd127, 1'b0, 8'd128);
        run_ticks(1);
        check_output("retrigger_env", env_out, 87);
        check_output("retrigger_state", state_out, 1);

        $display("[TB] corner events");
        run_ticks(11);
        check_output("retrigger_peak_state", state_out, 2);
        run_ticks(8);
        check_output("corner_sustain_state", state_out, 3);
        apply_stimulus(1'b1, 1'b0, 7'd0, 1'b0, 8'd128);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd128);
        check_output("vel0_release_state", state_out, 4);
        check_output("vel0_release_env", env_out, 135);
        apply_stimulus(1'b1, 1'b0, 7'd127, 1'b0, 8'd128);
        decay = 4'd15;
        wait_state(2);
        check_output("corner_decay_env", env_out, 255);
        apply_stimulus(1'b1, 1'b1, 7'd127, 1'b0, 8'd128);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd128);
        check_output("on_off_same_cycle_state", state_out, 1);
        check_output("on_off_same_cycle_env", env_out, 255);

        budget = 2 * MOD;
        while (m_pc != MOD - 1 && budget > 0) begin
            idle_cycle();
            budget--;
        end
        if (m_pc != MOD - 1) report_timeout("tick_phase", 1);
        drive(1'b0, 1'b1, 7'd0, 1'b0, 8'd128);
        apply_stimulus(1'b0, 1'b0, 7'd0, 1'b0, 8'd128);
        check_output("event_on_tick_state", state_out, 4);
        check_output("event_on_tick_env", env_out, 255);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) attack = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) decay = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) release_rate = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) sustain = 4'($urandom_range(0, 15));
            r   = int'($urandom_range(0, 199));
            on  = (r < 3) || (r == 7);
            off = (r >= 3 && r < 7);
            apply_stimulus(on, off,
                           ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
                           ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)));
            if (i == 1200) begin
                apply_stimulus(1'b1, 1'b0, 7'd127, 1'b0, 8'd128);
                run_ticks(3);
                reset_dut();
            end
        end

        repeat (4) idle_cycle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog: got no completion by %0t, expected finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
